// File: rtl/trap_ctrl_if.sv
// CSR access bus between the trap controller (master) and the CSR file (slave).
interface trap_ctrl_if #(
    parameter int MXLEN = 32
);
    logic [11:0]      csr_addr;
    logic             csr_rd_en;
    logic [MXLEN-1:0] csr_r_data;
    logic             csr_wr_en;
    logic [MXLEN-1:0] csr_w_data;

    modport master (
        output csr_addr, csr_rd_en, csr_wr_en, csr_w_data,
        input  csr_r_data
    );
    modport slave (
        input  csr_addr, csr_rd_en, csr_wr_en, csr_w_data,
        output csr_r_data
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry / MRET sequencer: writes mepc/mcause/mtval, reads mtvec/mepc, redirects the PC.
// Optional macro VECTORED_TRAP_EN enables vectored interrupt targets (base + 4*cause).
module trap_ctrl #(
    parameter int          MXLEN      = 32,
    parameter logic [11:0] CSR_MTVEC  = 12'h305,
    parameter logic [11:0] CSR_MEPC   = 12'h341,
    parameter logic [11:0] CSR_MCAUSE = 12'h342,
    parameter logic [11:0] CSR_MTVAL  = 12'h343
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             trap_req,
    input  logic             trap_is_irq,
    input  logic [4:0]       trap_cause,
    input  logic [MXLEN-1:0] trap_pc,
    input  logic [MXLEN-1:0] trap_tval,
    input  logic             mret_req,
    trap_ctrl_if.master      csr,
    output logic             exception,
    output logic             mret,
    output logic [MXLEN-1:0] mtvec_or_mepc,
    output logic             stall
);
    typedef enum logic [2:0] {
        IDLE, W_EPC, W_CAUSE, W_TVAL, R_VEC, REDIR, R_EPC, RET
    } state_t;

    state_t           state, nxt;
    logic             lat_irq;
    logic [4:0]       lat_cause;
    logic [MXLEN-1:0] lat_pc;
    logic [MXLEN-1:0] lat_tval;
    logic [MXLEN-1:0] vec_base;
    logic [MXLEN-1:0] trap_tgt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            lat_irq   <= 1'b0;
            lat_cause <= '0;
            lat_pc    <= '0;
            lat_tval  <= '0;
        end else begin
            state <= nxt;
            // Trap context is frozen as IDLE is left so the writes see stable values.
            if (state == IDLE && trap_req) begin
                lat_irq   <= trap_is_irq;
                lat_cause <= trap_cause;
                lat_pc    <= trap_pc;
                lat_tval  <= trap_tval;
            end
        end
    end

    assign vec_base = {csr.csr_r_data[MXLEN-1:2], 2'b00};

`ifdef VECTORED_TRAP_EN
    always_comb begin
        trap_tgt = vec_base;
        if (csr.csr_r_data[1:0] == 2'b01 && lat_irq)
            trap_tgt = vec_base + {{(MXLEN-7){1'b0}}, lat_cause, 2'b00};
    end
`else
    assign trap_tgt = vec_base;
`endif

    always_comb begin
        nxt            = state;
        csr.csr_addr   = '0;
        csr.csr_rd_en  = 1'b0;
        csr.csr_wr_en  = 1'b0;
        csr.csr_w_data = '0;
        exception      = 1'b0;
        mret           = 1'b0;
        mtvec_or_mepc  = '0;
        unique case (state)
            IDLE: begin
                if (trap_req)      nxt = W_EPC;
                else if (mret_req) nxt = R_EPC;
            end
            W_EPC: begin
                csr.csr_wr_en  = 1'b1;
                csr.csr_addr   = CSR_MEPC;
                csr.csr_w_data = {lat_pc[MXLEN-1:2], 2'b00};
                nxt            = W_CAUSE;
            end
            W_CAUSE: begin
                csr.csr_wr_en  = 1'b1;
                csr.csr_addr   = CSR_MCAUSE;
                csr.csr_w_data = {lat_irq, {(MXLEN-6){1'b0}}, lat_cause};
                nxt            = W_TVAL;
            end
            W_TVAL: begin
                csr.csr_wr_en  = 1'b1;
                csr.csr_addr   = CSR_MTVAL;
                csr.csr_w_data = lat_tval;
                nxt            = R_VEC;
            end
            R_VEC: begin
                csr.csr_rd_en = 1'b1;
                csr.csr_addr  = CSR_MTVEC;
                nxt           = REDIR;
            end
            REDIR: begin
                exception     = 1'b1;
                mtvec_or_mepc = trap_tgt;
                nxt           = IDLE;
            end
            R_EPC: begin
                csr.csr_rd_en = 1'b1;
                csr.csr_addr  = CSR_MEPC;
                nxt           = RET;
            end
            RET: begin
                // PC unit adds 4 itself, so mepc is passed through untouched.
                mret          = 1'b1;
                mtvec_or_mepc = csr.csr_r_data;
                nxt           = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    assign stall = (state != IDLE) | trap_req | mret_req;
endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl with a tiny CSR-file model supplying mtvec/mepc read data.
module tb_trap_ctrl;
    logic        CLK = 1'b0;
    logic        RST;
    logic        trap_req, trap_is_irq, mret_req;
    logic [4:0]  trap_cause;
    logic [31:0] trap_pc, trap_tval;
    logic        exception, mret, stall;
    logic [31:0] mtvec_or_mepc;

    logic [31:0] m_mtvec, m_mepc, rdata;
    int n_chk  = 0;
    int n_fail = 0;

    trap_ctrl_if #(.MXLEN(32)) bus ();

    trap_ctrl #(.MXLEN(32)) dut (
        .CLK(CLK), .RST(RST),
        .trap_req(trap_req), .trap_is_irq(trap_is_irq), .trap_cause(trap_cause),
        .trap_pc(trap_pc), .trap_tval(trap_tval), .mret_req(mret_req),
        .csr(bus),
        .exception(exception), .mret(mret), .mtvec_or_mepc(mtvec_or_mepc), .stall(stall)
    );

    always #5 CLK = ~CLK;

    assign bus.csr_r_data = rdata;

    // CSR file model: one-cycle read latency, mepc tracks writes.
    always @(posedge CLK) begin
        if (bus.csr_rd_en)
            rdata <= (bus.csr_addr == 12'h305) ? m_mtvec :
                     (bus.csr_addr == 12'h341) ? m_mepc  : 32'h0;
        if (bus.csr_wr_en && bus.csr_addr == 12'h341)
            m_mepc <= bus.csr_w_data;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_cyc(input string tag, input logic rd, input logic wr,
                           input logic [11:0] addr, input logic [31:0] wd,
                           input logic exc, input logic mr, input logic [31:0] tgt,
                           input logic stl);
        check({tag, ".rd"},    bus.csr_rd_en,  rd);
        check({tag, ".wr"},    bus.csr_wr_en,  wr);
        check({tag, ".addr"},  bus.csr_addr,   addr);
        check({tag, ".wdata"}, bus.csr_w_data, wd);
        check({tag, ".exc"},   exception,      exc);
        check({tag, ".mret"},  mret,           mr);
        check({tag, ".tgt"},   mtvec_or_mepc,  tgt);
        check({tag, ".stall"}, stall,          stl);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_in();
        trap_req = 0; mret_req = 0; trap_is_irq = 0;
        trap_cause = '0; trap_pc = '0; trap_tval = '0;
    endtask

    logic [31:0] vec_tgt;

    initial begin
        m_mtvec = 32'h200;
        idle_in();
        RST = 1;
        tick(); tick();
        #1 chk_cyc("reset", 0, 0, 12'h0, 32'h0, 0, 0, 32'h0, 0);
        RST = 0;

        // Basic exception entry
        tick();
        trap_req = 1; trap_cause = 5'd2; trap_pc = 32'h100; trap_tval = 32'hDEAD;
        #1 chk_cyc("t1.N", 0, 0, 12'h0, 32'h0, 0, 0, 32'h0, 1);
        tick(); idle_in();
        #1 chk_cyc("t1.epc", 0, 1, 12'h341, 32'h100, 0, 0, 32'h0, 1);
        tick(); #1 chk_cyc("t1.cause", 0, 1, 12'h342, 32'h2, 0, 0, 32'h0, 1);
        tick(); #1 chk_cyc("t1.tval", 0, 1, 12'h343, 32'hDEAD, 0, 0, 32'h0, 1);
        tick(); #1 chk_cyc("t1.rvec", 1, 0, 12'h305, 32'h0, 0, 0, 32'h0, 1);
        tick(); #1 chk_cyc("t1.redir", 0, 0, 12'h0, 32'h0, 1, 0, 32'h200, 1);
        tick(); #1 chk_cyc("t1.done", 0, 0, 12'h0, 32'h0, 0, 0, 32'h0, 0);

        // MRET using mepc written above
        mret_req = 1;
        #1 chk_cyc("r1.N", 0, 0, 12'h0, 32'h0, 0, 0, 32'h0, 1);
        tick(); idle_in();
        #1 chk_cyc("r1.repc", 1, 0, 12'h341, 32'h0, 0, 0, 32'h0, 1);
        tick();
        #1 chk_cyc("r1.ret", 0, 0, 12'h0, 32'h0, 0, 1, 32'h100, 1);
        check("r1.pc_load", mtvec_or_mepc + 32'd4, 32'h104);
        tick(); #1 chk_cyc("r1.done", 0, 0, 12'h0, 32'h0, 0, 0, 32'h0, 0);

        // Trap and mret together; irq cause 7, unaligned pc, vectored mtvec
        m_mtvec = 32'h201;
`ifdef VECTORED_TRAP_EN
        vec_tgt = 32'h21C;
`else
        vec_tgt = 32'h200;
`endif
        trap_req = 1; mret_req = 1; trap_is_irq = 1; trap_cause = 5'd7;
        trap_pc = 32'h10E; trap_tval = 32'h55;
        tick(); idle_in();
        #1 chk_cyc("t2.epc", 0, 1, 12'h341, 32'h10C, 0, 0, 32'h0, 1);
        tick();
        mret_req = 1;  // ignored outside IDLE
        #1 chk_cyc("t2.cause", 0, 1, 12'h342, 32'h80000007, 0, 0, 32'h0, 1);
        tick(); mret_req = 0;
        #1 chk_cyc("t2.tval", 0, 1, 12'h343, 32'h55, 0, 0, 32'h0, 1);
        tick(); #1 chk_cyc("t2.rvec", 1, 0, 12'h305, 32'h0, 0, 0, 32'h0, 1);
        tick(); #1 chk_cyc("t2.redir", 0, 0, 12'h0, 32'h0, 1, 0, vec_tgt, 1);
        tick(); #1 chk_cyc("t2.done", 0, 0, 12'h0, 32'h0, 0, 0, 32'h0, 0);

        // Exception (not irq) with mode bits 01 still goes to base
        trap_req = 1; trap_cause = 5'd7; trap_pc = 32'h300; trap_tval = 32'h1;
        tick(); idle_in();
        tick(); tick(); tick();
        #1 chk_cyc("t3.rvec", 1, 0, 12'h305, 32'h0, 0, 0, 32'h0, 1);
        tick(); #1 chk_cyc("t3.redir", 0, 0, 12'h0, 32'h0, 1, 0, 32'h200, 1);
        tick();

        // Reset in W_CAUSE aborts the sequence
        trap_req = 1; trap_cause = 5'd3; trap_pc = 32'h400; trap_tval = 32'hBEEF;
        tick(); idle_in();
        tick();
        #1 chk_cyc("t4.cause", 0, 1, 12'h342, 32'h3, 0, 0, 32'h0, 1);
        RST = 1;
        tick(); RST = 0;
        #1 chk_cyc("t4.rst", 0, 0, 12'h0, 32'h0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            #1 chk_cyc("t4.quiet", 0, 0, 12'h0, 32'h0, 0, 0, 32'h0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
